// File: rtl/cpu_common_pkg.sv
// Shared CPU front-end definitions: instruction/pc widths, the fetch queue
// entry payload, and the default reset vector.
package cpu_common_pkg;

    localparam int unsigned INST_W     = 16;
    localparam int unsigned PC_W       = 16;
    localparam int unsigned DEF_ADDR_W = 16;

    localparam logic [PC_W-1:0] RESET_VECTOR_DEF = '0;

    // One buffered instruction and the word address it was fetched from.
    // pc is carried at full PC_W; narrower fetch units zero-extend into it.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions.
// Ports:
//   clk, rst_async  : clock, asynchronous active-high reset
//   push, push_data : write one entry (never issued while full)
//   pop             : remove the head (never issued while empty)
//   flush           : drop all entries; has priority over push/pop
//   head            : oldest entry; holds its last value when empty
//   count           : number of valid entries, 0..2
module fetch_queue
    import cpu_common_pkg::*;
(
    input  logic         clk,
    input  logic         rst_async,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t tail;

    // Head/tail are kept as a shift pair so the head register only changes
    // when a new oldest entry exists; an empty queue keeps showing the last one.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop && (count == 2'd2)) begin
                head <= tail;
            end
            if (push) begin
                if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                    head <= push_data;
                end else begin
                    tail <= push_data;
                end
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: drives a 1-cycle-latency instruction memory,
// buffers returned words in a 2-entry queue and hands them to decode with a
// valid/ready handshake. Supports redirect (flush + restart) and halt.
// Ports:
//   clk, rst_async              : clock, asynchronous active-high reset
//   mem_req, mem_addr           : read request (combinational) and its address
//   mem_rdata                   : read data, one cycle after an accepted request
//   inst, inst_pc, inst_valid   : queue head presented to decode
//   inst_ready                  : decode takes the head when inst_valid is high
//   redirect, redirect_addr     : discard all fetched/in-flight work, restart
//   halt                        : stop issuing new requests
module fetch
    import cpu_common_pkg::*;
#(
    parameter int unsigned       ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic              clk,
    input  logic              rst_async,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt
);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;
    logic [1:0]        count;
    logic [2:0]        credits_used;
    logic              take;
    logic              push;
    logic              issue;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    assign inst_valid = (count != 2'd0);

    // A redirect cycle ignores the consumer: the queue is flushed anyway.
    assign take = inst_valid & inst_ready & ~redirect;

    // Buffered plus in-flight words, net of this cycle's take, must leave room
    // for the response of a new request so the queue can never overflow.
    assign credits_used = 3'(count) + 3'(inflight_q) - 3'(take);
    assign issue        = ~rst_async & ~halt & ~redirect & (credits_used < 3'd2);

    assign mem_req  = issue;
    assign mem_addr = fetch_pc;

    // A response landing in a redirect cycle belongs to the old stream.
    assign push       = inflight_q & ~redirect;
    assign push_entry = '{inst: mem_rdata, pc: PC_W'(inflight_pc_q)};

    assign inst    = head.inst;
    assign inst_pc = ADDR_W'(head.pc);

    // Fetch pointer and in-flight tracking.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            fetch_pc      <= RESET_VECTOR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect) begin
            fetch_pc   <= redirect_addr;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fetch_pc      <= fetch_pc + ADDR_W'(1);
                inflight_pc_q <= fetch_pc;
            end
        end
    end

    fetch_queue u_queue (
        .clk       (clk),
        .rst_async (rst_async),
        .push      (push),
        .push_data (push_entry),
        .pop       (take),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

endmodule
